// File: rtl/ysyx_23060221_icache.sv
// rtl/ysyx_23060221_icache.sv - direct-mapped read-only instruction cache with AXI4 line refill
// Hits answer from local storage; misses refill a whole line with one INCR burst.
module ysyx_23060221_icache #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fence_i,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic [3:0]  s_rid,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic [3:0]  m_rid
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int OB = 2 + OW;
  localparam int TW = 32 - OB - IW;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] MISS_AR = 3'd2;
  localparam logic [2:0] MISS_R  = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]      state;
  logic [31:0]     req_addr;
  logic [3:0]      req_id;
  logic            fence_pending;
  logic            err;
  logic [OW-1:0]   cnt;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_arr  [SETS];
  logic [31:0]     data_arr [SETS][LINE_WORDS];

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          hit;
  logic          beat;
  logic          err_next;
  logic [31:0]   beat_word;
  logic          unused_ok;

  assign req_off  = req_addr[OB-1:2];
  assign req_idx  = req_addr[OB+IW-1:OB];
  assign req_tag  = req_addr[31:OB+IW];
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign beat     = (state == MISS_R) && m_rvalid;
  assign err_next = err | (m_rresp != 2'b00);
  // The requested word may be the beat arriving right now, not yet in the array.
  assign beat_word = (cnt == req_off) ? m_rdata : data_arr[req_idx][req_off];

  assign s_arready = (state == IDLE) && !fence_pending;
  assign s_rlast   = s_rvalid;
  assign m_arid    = 4'd0;
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign unused_ok = ^{s_arlen, s_arsize, s_arburst, s_araddr[1:0], m_rid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      req_addr      <= '0;
      req_id        <= '0;
      fence_pending <= 1'b0;
      err           <= 1'b0;
      cnt           <= '0;
      valid         <= '0;
      s_rvalid      <= 1'b0;
      s_rdata       <= '0;
      s_rresp       <= 2'b00;
      s_rid         <= '0;
      m_arvalid     <= 1'b0;
      m_rready      <= 1'b0;
      m_araddr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fence_pending) begin
            valid         <= '0;
            fence_pending <= 1'b0;
          end else if (s_arvalid) begin
            req_addr <= s_araddr;
            req_id   <= s_arid;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            s_rvalid <= 1'b1;
            s_rdata  <= data_arr[req_idx][req_off];
            s_rresp  <= 2'b00;
            s_rid    <= req_id;
            state    <= RESP;
          end else begin
            m_arvalid <= 1'b1;
            m_araddr  <= {req_addr[31:OB], {OB{1'b0}}};
            state     <= MISS_AR;
          end
        end
        MISS_AR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            cnt       <= '0;
            err       <= 1'b0;
            state     <= MISS_R;
          end
        end
        MISS_R: begin
          if (m_rvalid) begin
            cnt <= cnt + {{(OW-1){1'b0}}, 1'b1};
            err <= err_next;
            // Only rlast ends the refill; the beat count is not enforced.
            if (m_rlast) begin
              m_rready       <= 1'b0;
              valid[req_idx] <= ~err_next;
              s_rvalid       <= 1'b1;
              s_rdata        <= beat_word;
              s_rresp        <= err_next ? 2'b10 : 2'b00;
              s_rid          <= req_id;
              state          <= RESP;
            end
          end
        end
        RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            err      <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (fence_i) fence_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      data_arr[req_idx][cnt] <= m_rdata;
      if (m_rlast) tag_arr[req_idx] <= req_tag;
    end
  end
endmodule

// File: tb/tb_ysyx_23060221_icache.sv
// tb/tb_ysyx_23060221_icache.sv - scoreboard bench for ysyx_23060221_icache
// Memory word at address A is A ^ 0xA5A5A5A5; the cache model tracks line numbers per set.
module tb_ysyx_23060221_icache;
  localparam int SETS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        fence_i;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [3:0]  m_rid;

  always #5 clk = ~clk;

  ysyx_23060221_icache #(.SETS(SETS), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .fence_i(fence_i),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  bit          model_valid [SETS];
  logic [31:0] model_line  [SETS];

  int          burst_count = 0;
  logic [31:0] last_baddr = '0;
  logic [7:0]  last_blen = '0;
  int          err_beat = -1;

  int          resp_count = 0;
  logic        post_arready = 1'b0;
  int          hold_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5A5A5;
  endfunction

  // Memory-side slave with random AR and R stalls and optional SLVERR beat.
  logic [31:0] mem_a;
  int          mem_st, mem_gap, mem_g, mem_len;
  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rid = 0;
    forever begin
      @(negedge clk);
      if (rst && m_arvalid) begin
        mem_a  = m_araddr;
        mem_st = $urandom_range(0, 3);
        for (int k = 0; k < mem_st; k++) begin
          @(negedge clk);
          check("m_araddr_stable", m_araddr, mem_a);
          check("m_arvalid_held", m_arvalid, 1);
        end
        m_arready = 1;
        mem_len = int'(m_arlen);
        @(negedge clk);
        m_arready = 0;
        burst_count++;
        last_baddr = mem_a;
        last_blen = 8'(mem_len);
        for (int b = 0; b <= mem_len; b++) begin
          mem_gap = $urandom_range(0, 2);
          for (int k = 0; k < mem_gap; k++) @(negedge clk);
          m_rvalid = 1;
          m_rdata  = mem_word(mem_a + 32'(4 * b));
          m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
          m_rlast  = (b == mem_len);
          m_rid    = 4'd0;
          mem_g = 0;
          while (!m_rready && mem_g < 50) begin @(negedge clk); mem_g++; end
          if (mem_g >= 50) check("m_rready_timeout", 0, 1);
          @(negedge clk);
          m_rvalid = 0; m_rlast = 0; m_rresp = 0;
        end
      end
    end
  end

  // Response monitor: random or forced s_rready backpressure, pops the scoreboard on acceptance.
  bit          mon_have = 0;
  int          mon_wait = 0;
  logic [31:0] mon_data;
  logic [3:0]  mon_id;
  logic [1:0]  mon_resp;
  exp_t        mon_e;
  initial begin
    s_rready = 0;
    forever begin
      @(negedge clk);
      if (s_rvalid) begin
        check("s_rlast", s_rlast, 1);
        check("s_arready_busy", s_arready, 0);
        if (!mon_have) begin
          mon_have = 1;
          mon_data = s_rdata; mon_id = s_rid; mon_resp = s_rresp;
          mon_wait = (hold_req > 0) ? hold_req : $urandom_range(0, 2);
          hold_req = 0;
        end else begin
          check("s_rdata_stable", s_rdata, mon_data);
          check("s_rid_stable", s_rid, mon_id);
          check("s_rresp_stable", s_rresp, mon_resp);
        end
        if (mon_wait == 0) begin
          if (!s_rready) begin
            s_rready = 1;
            if (exp_q.size() == 0) check("unexpected_response", 1, 0);
            else begin
              mon_e = exp_q.pop_front();
              check("s_rdata", s_rdata, mon_e.data);
              check("s_rresp", s_rresp, mon_e.resp);
              check("s_rid", s_rid, mon_e.id);
            end
          end
        end else begin
          s_rready = 0;
          mon_wait--;
        end
      end else if (mon_have) begin
        mon_have = 0;
        s_rready = 0;
        post_arready = s_arready;
        resp_count++;
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int eb, input bit fence_mid);
    logic [31:0] line;
    int set, before_b, before_r, g;
    bit hit;
    exp_t e;
    line = addr >> 4;
    set  = int'(line % SETS);
    hit  = model_valid[set] && (model_line[set] == line);
    e.data = mem_word(addr);
    e.resp = (!hit && eb >= 0) ? 2'b10 : 2'b00;
    e.id   = id;
    exp_q.push_back(e);
    if (!hit) begin
      model_valid[set] = (eb < 0);
      model_line[set]  = line;
    end
    err_beat = eb;
    before_b = burst_count;
    before_r = resp_count;
    @(negedge clk);
    s_arvalid = 1; s_araddr = addr; s_arid = id;
    g = 0;
    while (!s_arready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) check("s_arready_timeout", 0, 1);
    @(negedge clk);
    s_arvalid = 0;
    check("lookup_no_rvalid", s_rvalid, 0);
    @(negedge clk);
    if (hit) check("hit_latency_rvalid", s_rvalid, 1);
    else begin
      check("miss_m_arvalid", m_arvalid, 1);
      check("miss_no_rvalid", s_rvalid, 0);
    end
    if (fence_mid) begin
      g = 0;
      while (!m_rready && g < 100) begin @(negedge clk); g++; end
      fence_i = 1;
      @(negedge clk);
      fence_i = 0;
    end
    g = 0;
    while (resp_count == before_r && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) check("response_timeout", 0, 1);
    check("burst_count", burst_count - before_b, hit ? 0 : 1);
    if (!hit) begin
      check("burst_addr", last_baddr, {addr[31:4], 4'h0});
      check("burst_len", last_blen, 3);
    end
    check("arready_after_resp", post_arready, fence_mid ? 0 : 1);
    if (fence_mid) for (int i = 0; i < SETS; i++) model_valid[i] = 0;
    err_beat = -1;
  endtask

  task automatic fence_idle();
    @(negedge clk);
    fence_i = 1;
    @(negedge clk);
    fence_i = 0;
    check("fence_blocks_ar", s_arready, 0);
    @(negedge clk);
    check("fence_released_ar", s_arready, 1);
    for (int i = 0; i < SETS; i++) model_valid[i] = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] raddr;
  initial begin
    for (int i = 0; i < SETS; i++) begin model_valid[i] = 0; model_line[i] = '0; end
    rst = 0; fence_i = 0; s_arvalid = 0; s_araddr = 0; s_arid = 0;
    s_arlen = 0; s_arsize = 3'b010; s_arburst = 2'b01;
    repeat (3) @(negedge clk);
    check("rst_s_arready", s_arready, 1);
    check("rst_s_rvalid", s_rvalid, 0);
    check("rst_s_rlast", s_rlast, 0);
    check("rst_s_rresp", s_rresp, 0);
    check("rst_s_rdata", s_rdata, 0);
    check("rst_s_rid", s_rid, 0);
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_m_rready", m_rready, 0);
    check("rst_m_araddr", m_araddr, 0);
    check("m_arid", m_arid, 0);
    check("m_arsize", m_arsize, 3'b010);
    check("m_arburst", m_arburst, 2'b01);
    check("m_arlen", m_arlen, 3);
    rst = 1;

    do_read(32'h80000008, 4'd3, -1, 0);
    do_read(32'h8000000C, 4'd5, -1, 0);
    do_read(32'h80000000, 4'd1, -1, 0);
    do_read(32'h80000100, 4'd2, -1, 0);
    do_read(32'h80000000, 4'd7, -1, 0);
    do_read(32'h80000204, 4'd9, 2, 0);
    do_read(32'h80000204, 4'd10, -1, 0);
    do_read(32'h80000300, 4'd11, -1, 1);
    do_read(32'h80000300, 4'd12, -1, 0);
    hold_req = 5;
    do_read(32'h80000304, 4'd13, -1, 0);
    fence_idle();
    do_read(32'h80000304, 4'd14, -1, 0);

    for (int n = 0; n < 60; n++) begin
      raddr = 32'h80000000 + (32'($urandom_range(0, 2)) << 8)
            + (32'($urandom_range(0, 15)) << 4) + (32'($urandom_range(0, 3)) << 2);
      if (n % 17 == 16) fence_idle();
      do_read(raddr, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1, 0);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
